// File: rtl/shift_reg_sipo_rx.sv
// Serial-in/parallel-out receiver: frames start on i_start, bits are sampled on
// i_trigger, and each completed word is published on o_q with done/valid/overrun status.
module shift_reg_sipo_rx #(
  parameter int N         = 8,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic         i_clk,
  input  logic         i_reset_n,
  input  logic         i_trigger,
  input  logic         i_start,
  input  logic         i_d,
  input  logic         i_ack,
  output logic [N-1:0] o_q,
  output logic         o_busy,
  output logic         o_last_tick,
  output logic         o_done,
  output logic         o_valid,
  output logic         o_overrun
);

  localparam int CW = $clog2(N);
  localparam logic [CW-1:0] LAST_CNT = CW'(N - 1);

  typedef enum logic {
    IDLE = 1'b0,
    RECV = 1'b1
  } state_t;

  state_t         r_state, w_state_next;
  logic [CW-1:0]  r_cnt, w_cnt_next;
  logic [N-1:0]   r_sr, w_sr_next;
  logic [N-1:0]   r_q, w_q_next;
  logic [N-1:0]   w_shift;
  logic           r_done, w_done_next;
  logic           r_valid, w_valid_next;
  logic           r_overrun, w_overrun_next;
  logic           w_complete;

  // Shift value including the bit currently on i_d; used for both sampling and completion.
  generate
    if (MSB_FIRST) begin : g_msb_first
      assign w_shift = {r_sr[N-2:0], i_d};
    end else begin : g_lsb_first
      assign w_shift = {i_d, r_sr[N-1:1]};
    end
  endgenerate

  assign w_complete = (r_state == RECV) && i_trigger && (r_cnt == LAST_CNT);

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_state   <= IDLE;
      r_cnt     <= '0;
      r_sr      <= '0;
      r_q       <= '0;
      r_done    <= 1'b0;
      r_valid   <= 1'b0;
      r_overrun <= 1'b0;
    end else begin
      r_state   <= w_state_next;
      r_cnt     <= w_cnt_next;
      r_sr      <= w_sr_next;
      r_q       <= w_q_next;
      r_done    <= w_done_next;
      r_valid   <= w_valid_next;
      r_overrun <= w_overrun_next;
    end
  end

  always_comb begin
    w_state_next   = r_state;
    w_cnt_next     = r_cnt;
    w_sr_next      = r_sr;
    w_q_next       = r_q;
    w_done_next    = 1'b0;
    w_valid_next   = r_valid;
    w_overrun_next = r_overrun;

    case (r_state)
      IDLE: begin
        if (i_start) begin
          w_state_next = RECV;
          w_cnt_next   = '0;
          w_sr_next    = '0;
        end
      end
      RECV: begin
        if (w_complete) begin
          // A coincident start chains straight into the next frame.
          w_q_next     = w_shift;
          w_cnt_next   = '0;
          w_sr_next    = '0;
          w_done_next  = 1'b1;
          w_state_next = i_start ? RECV : IDLE;
        end else if (i_start) begin
          w_cnt_next = '0;
          w_sr_next  = '0;
        end else if (i_trigger) begin
          w_sr_next  = w_shift;
          w_cnt_next = r_cnt + CW'(1);
        end
      end
      default: w_state_next = IDLE;
    endcase

    // A completion wins over a coincident ack: the new word is still unconsumed.
    if (w_complete) begin
      w_valid_next = 1'b1;
      if (!i_ack && r_valid) begin
        w_overrun_next = 1'b1;
      end
    end else if (i_ack) begin
      w_valid_next   = 1'b0;
      w_overrun_next = 1'b0;
    end
  end

  assign o_q         = r_q;
  assign o_busy      = (r_state == RECV);
  assign o_last_tick = (r_state == RECV) && (r_cnt == LAST_CNT);
  assign o_done      = r_done;
  assign o_valid     = r_valid;
  assign o_overrun   = r_overrun;

endmodule

// File: tb/tb_shift_reg_sipo_rx.sv
// Bench for shift_reg_sipo_rx: directed scenarios then random traffic, checked against
// a bit-list model of the receiver, with MSB-first and LSB-first instances driven in parallel.
module tb_shift_reg_sipo_rx;
  localparam int N = 8;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         trig = 1'b0, start = 1'b0, d = 1'b0, ack = 1'b0;
  logic [N-1:0] q_m, q_l;
  logic         busy_m, last_m, done_m, valid_m, ovr_m;
  logic         busy_l, last_l, done_l, valid_l, ovr_l;

  int errors = 0;
  int checks = 0;
  int done_seen = 0;

  // Model: a frame is just the list of bits received so far.
  bit           m_in_frame;
  int           m_nbits;
  bit           m_bits[N];
  logic [N-1:0] m_q_msb, m_q_lsb;
  bit           m_done, m_valid, m_ovr;

  always #5 clk = ~clk;

  shift_reg_sipo_rx #(.N(N), .MSB_FIRST(1'b1)) dut_m (
    .i_clk(clk), .i_reset_n(rst_n), .i_trigger(trig), .i_start(start), .i_d(d), .i_ack(ack),
    .o_q(q_m), .o_busy(busy_m), .o_last_tick(last_m), .o_done(done_m),
    .o_valid(valid_m), .o_overrun(ovr_m));

  shift_reg_sipo_rx #(.N(N), .MSB_FIRST(1'b0)) dut_l (
    .i_clk(clk), .i_reset_n(rst_n), .i_trigger(trig), .i_start(start), .i_d(d), .i_ack(ack),
    .o_q(q_l), .o_busy(busy_l), .o_last_tick(last_l), .o_done(done_l),
    .o_valid(valid_l), .o_overrun(ovr_l));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [N-1:0] word_of(input bit msb_first);
    logic [N-1:0] w = '0;
    for (int i = 0; i < N; i++) begin
      if (msb_first) w[N-1-i] = m_bits[i];
      else           w[i]     = m_bits[i];
    end
    return w;
  endfunction

  task automatic model_reset();
    m_in_frame = 0; m_nbits = 0;
    m_q_msb = '0; m_q_lsb = '0;
    m_done = 0; m_valid = 0; m_ovr = 0;
  endtask

  task automatic model_edge(input bit t, input bit s, input bit din, input bit a);
    bit complete;
    complete = m_in_frame && t && (m_nbits == N - 1);
    m_done = complete;
    if (complete) begin
      m_bits[N-1] = din;
      m_q_msb = word_of(1'b1);
      m_q_lsb = word_of(1'b0);
      if (!a && m_valid) m_ovr = 1;
      m_valid = 1;
      m_in_frame = s;
      m_nbits = 0;
    end else begin
      if (a) begin m_valid = 0; m_ovr = 0; end
      if (!m_in_frame) begin
        if (s) begin m_in_frame = 1; m_nbits = 0; end
      end else if (s) begin
        m_nbits = 0;
      end else if (t) begin
        m_bits[m_nbits] = din;
        m_nbits++;
      end
    end
  endtask

  task automatic check_all();
    chk("q_msb",     32'(q_m),     32'(m_q_msb));
    chk("q_lsb",     32'(q_l),     32'(m_q_lsb));
    chk("busy",      32'(busy_m),  32'(m_in_frame));
    chk("last_tick", 32'(last_m),  32'(m_in_frame && m_nbits == N - 1));
    chk("done",      32'(done_m),  32'(m_done));
    chk("done_lsb",  32'(done_l),  32'(m_done));
    chk("valid",     32'(valid_m), 32'(m_valid));
    chk("overrun",   32'(ovr_m),   32'(m_ovr));
  endtask

  // One clock: drive inputs just after an edge, model the next edge, check 1ns after it.
  task automatic step(input bit t, input bit s, input bit din, input bit a);
    trig = t; start = s; d = din; ack = a;
    @(posedge clk);
    model_edge(t, s, din, a);
    #1;
    check_all();
    if (done_m === 1'b1) begin
      done_seen++;
      $display("word msb=%02h lsb=%02h valid=%0b overrun=%0b t=%0t", q_m, q_l, valid_m, ovr_m, $time);
    end
  endtask

  task automatic send_bits(input logic [N-1:0] seq, input bit start_on_last);
    for (int i = N - 1; i >= 0; i--) step(1'b1, (i == 0) && start_on_last, seq[i], 1'b0);
  endtask

  task automatic do_reset();
    rst_n = 1'b0; trig = 0; start = 0; d = 0; ack = 0;
    #1;
    chk("rst_q",    32'(q_m),    32'h0);
    chk("rst_busy", 32'(busy_m), 32'h0);
    chk("rst_last", 32'(last_m), 32'h0);
    chk("rst_flags", 32'({done_m, valid_m, ovr_m, done_l}), 32'h0);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check_all();
  endtask

  initial begin
    int base;
    model_reset();
    #2;
    do_reset();

    // Basic A5 frame
    base = done_seen;
    step(0, 1, 0, 0);
    send_bits(8'hA5, 1'b0);
    chk("basic_q", 32'(q_m), 32'hA5);
    step(0, 0, 0, 0);
    chk("basic_done_cnt", 32'(done_seen - base), 32'd1);

    // Gap of 5 idle cycles between bits 3 and 4, then triggers while idle
    step(0, 0, 0, 1);
    step(0, 1, 0, 0);
    for (int i = 7; i >= 4; i--) step(1, 0, (8'hA5 >> i) & 1, 0);
    repeat (5) step(0, 0, 1, 0);
    for (int i = 3; i >= 0; i--) step(1, 0, (8'hA5 >> i) & 1, 0);
    chk("gap_q", 32'(q_m), 32'hA5);
    repeat (6) step(1, 0, 1'($urandom), 0);
    chk("idle_busy", 32'(busy_m), 32'h0);

    // Restart after 4 bits, then 3C
    base = done_seen;
    step(0, 1, 0, 0);
    repeat (4) step(1, 0, 1, 0);
    step(0, 1, 0, 0);
    send_bits(8'h3C, 1'b0);
    step(0, 0, 0, 0);
    chk("restart_q", 32'(q_m), 32'h3C);
    chk("restart_done_cnt", 32'(done_seen - base), 32'd1);

    // Back-to-back A5 then 5A without ack
    step(0, 0, 0, 1);
    base = done_seen;
    step(0, 1, 0, 0);
    send_bits(8'hA5, 1'b1);
    chk("b2b_busy", 32'(busy_m), 32'h1);
    send_bits(8'h5A, 1'b0);
    step(0, 0, 0, 0);
    chk("b2b_q", 32'(q_m), 32'h5A);
    chk("b2b_done_cnt", 32'(done_seen - base), 32'd2);
    chk("b2b_overrun", 32'(ovr_m), 32'h1);
    step(0, 0, 0, 1);
    chk("b2b_ack", 32'({valid_m, ovr_m}), 32'h0);

    // LSB-first ordering
    step(0, 1, 0, 0);
    send_bits(8'b10100101, 1'b0);
    chk("lsb_q_a5", 32'(q_l), 32'hA5);
    step(0, 1, 0, 1);
    send_bits(8'b11000000, 1'b0);
    chk("lsb_q_03", 32'(q_l), 32'h03);

    // Reset mid-frame, then a clean frame
    base = done_seen;
    step(0, 1, 0, 0);
    repeat (5) step(1, 0, 1, 0);
    do_reset();
    repeat (3) step(1, 0, 1, 0);
    chk("post_rst_idle", 32'(busy_m), 32'h0);
    chk("rst_no_done", 32'(done_seen - base), 32'd0);
    step(0, 1, 0, 0);
    send_bits(8'h96, 1'b0);
    chk("post_rst_q", 32'(q_m), 32'h96);

    // Random traffic
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 599) == 0) begin
        do_reset();
      end else begin
        step(1'($urandom), $urandom_range(0, 15) == 0, 1'($urandom), $urandom_range(0, 7) == 0);
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

endmodule
